// File: rtl/game_timer.sv
// Countdown timer paired with the game-state FSM: prescales Clock to one-second
// ticks, counts GAME_SECONDS down and holds TimerDone for DONE_HOLD cycles.
module game_timer #(
  parameter int CLOCK_HZ     = 50000000,
  parameter int GAME_SECONDS = 60,
  parameter int SEC_W        = 7,
  parameter int DONE_HOLD    = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             State,
  input  logic             Pause,
  output logic             TimerDone,
  output logic [SEC_W-1:0] SecondsLeft,
  output logic             Tick,
  output logic [1:0]       DbgState   // 0 IDLE, 1 RUN, 2 DONE, 3 EXPIRED
);

  localparam int PW = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
  localparam int HW = $clog2(DONE_HOLD + 1);

  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLOCK_HZ - 1);
  localparam logic [HW-1:0]    HOLD_LAST  = HW'(DONE_HOLD - 1);
  localparam logic [SEC_W-1:0] SEC_RELOAD = SEC_W'(GAME_SECONDS);
  localparam logic [SEC_W-1:0] SEC_ONE    = SEC_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             done_q, done_d;
  logic             tick_q, tick_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      hold_q  <= '0;
      sec_q   <= SEC_RELOAD;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
    end
  end

  // Handshake with the game FSM: State=1 requests a game; TimerDone is a
  // DONE_HOLD-cycle pulse, after which we wait for State=0 before re-arming.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
    tick_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        hold_d  = '0;
        sec_d   = SEC_RELOAD;
        if (State) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (!State) begin
          // An abort on the same edge as the final tick still wins.
          state_d = IDLE;
          presc_d = '0;
          sec_d   = SEC_RELOAD;
        end else if (!Pause) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (sec_q != '0) begin
              sec_d  = sec_q - SEC_ONE;
              tick_d = 1'b1;
            end
            if (sec_q == SEC_ONE) begin
              state_d = DONE;
              hold_d  = '0;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end

      DONE: begin
        sec_d = '0;
        if (!State) begin
          state_d = IDLE;
          presc_d = '0;
          hold_d  = '0;
          sec_d   = SEC_RELOAD;
        end else if (hold_q == HOLD_LAST) begin
          state_d = EXPIRED;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
          done_d = 1'b1;
        end
      end

      EXPIRED: begin
        sec_d = '0;
        if (!State) begin
          state_d = IDLE;
          presc_d = '0;
          sec_d   = SEC_RELOAD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign TimerDone   = done_q;
  assign SecondsLeft = sec_q;
  assign Tick        = tick_q;
  assign DbgState    = state_q;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: directed scenarios with fixed expectations, then a
// randomized run compared against an elapsed-cycle reference model.
module tb_game_timer;

  localparam int HZ   = 4;
  localparam int GS   = 3;
  localparam int HOLD = 2;
  localparam int SW   = 7;

  logic          Clock;
  logic          Reset;
  logic          State;
  logic          Pause;
  logic          TimerDone;
  logic [SW-1:0] SecondsLeft;
  logic          Tick;
  logic [1:0]    DbgState;

  int n_checks;
  int n_errors;

  // Reference model: a game is "playing" or "over"; remaining time is derived
  // from the count of unpaused cycles elapsed since the game started.
  int            m_phase;    // 0 waiting, 1 playing, 2 over
  int            m_elapsed;
  int            m_over;
  logic          m_done;
  logic          m_tick;
  logic [SW-1:0] m_sec;

  game_timer #(
    .CLOCK_HZ(HZ), .GAME_SECONDS(GS), .SEC_W(SW), .DONE_HOLD(HOLD)
  ) dut (
    .Clock(Clock), .Reset(Reset), .State(State), .Pause(Pause),
    .TimerDone(TimerDone), .SecondsLeft(SecondsLeft), .Tick(Tick),
    .DbgState(DbgState)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic void model_step(input logic r, input logic s, input logic p);
    m_tick = 1'b0;
    if (r) begin
      m_phase = 0; m_elapsed = 0; m_over = 0;
      m_done = 1'b0; m_sec = SW'(GS);
    end else if (!s) begin
      m_phase = 0; m_done = 1'b0; m_sec = SW'(GS);
    end else if (m_phase == 0) begin
      m_phase = 1; m_elapsed = 0;
    end else if (m_phase == 1) begin
      if (!p) begin
        m_elapsed++;
        if (m_elapsed % HZ == 0) m_tick = 1'b1;
        m_sec = SW'(GS - m_elapsed / HZ);
        if (m_elapsed == GS * HZ) begin
          m_phase = 2; m_over = 0; m_done = 1'b1;
        end
      end
    end else begin
      m_over++;
      m_done = (m_over < HOLD);
      m_sec = '0;
    end
  endfunction

  task automatic step(input logic r, input logic s, input logic p);
    Reset = r; State = s; Pause = p;
    @(posedge Clock);
    model_step(r, s, p);
    @(negedge Clock);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (DbgState !== 2'd0) begin n_errors++; $display("FAIL reset_state got %0d exp 0", DbgState); end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (SecondsLeft !== SW'(3) || TimerDone !== 1'b0 || Tick !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_idle cyc=%0d got sec=%0d done=%b tick=%b exp sec=3 done=0 tick=0",
                 i, SecondsLeft, TimerDone, Tick);
      end
    end
  endtask

  // Full unpaused countdown from IDLE; E0 is the RUN-entry edge.
  task automatic test_countdown(input string tag);
    logic [SW-1:0] es;
    logic ed, et;
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (DbgState !== 2'd1 || SecondsLeft !== SW'(3)) begin
      n_errors++; $display("FAIL %s_entry got st=%0d sec=%0d exp st=1 sec=3", tag, DbgState, SecondsLeft);
    end
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b1, 1'b0);
      et = (k == 4 || k == 8 || k == 12);
      es = (k < 4) ? SW'(3) : (k < 8) ? SW'(2) : (k < 12) ? SW'(1) : SW'(0);
      ed = (k == 12 || k == 13);
      n_checks++;
      if (Tick !== et || SecondsLeft !== es || TimerDone !== ed) begin
        n_errors++;
        $display("FAIL %s E%0d got tick=%b sec=%0d done=%b exp tick=%b sec=%0d done=%b",
                 tag, k, Tick, SecondsLeft, TimerDone, et, es, ed);
      end
    end
  endtask

  task automatic test_pause();
    logic [SW-1:0] es;
    logic ed, et;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      step(1'b0, 1'b1, (k >= 6 && k <= 10));
      et = (k == 4 || k == 13 || k == 17);
      es = (k < 4) ? SW'(3) : (k < 13) ? SW'(2) : (k < 17) ? SW'(1) : SW'(0);
      ed = (k == 17 || k == 18);
      n_checks++;
      if (Tick !== et || SecondsLeft !== es || TimerDone !== ed) begin
        n_errors++;
        $display("FAIL pause E%0d got tick=%b sec=%0d done=%b exp tick=%b sec=%0d done=%b",
                 k, Tick, SecondsLeft, TimerDone, et, es, ed);
      end
    end
  endtask

  task automatic test_abort();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (SecondsLeft !== SW'(2)) begin n_errors++; $display("FAIL abort_pre got sec=%0d exp 2", SecondsLeft); end
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (DbgState !== 2'd0 || SecondsLeft !== SW'(3) || TimerDone !== 1'b0 || Tick !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_idle got st=%0d sec=%0d done=%b tick=%b exp st=0 sec=3 done=0 tick=0",
               DbgState, SecondsLeft, TimerDone, Tick);
    end
    test_countdown("restart");
  endtask

  task automatic test_expired();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (TimerDone !== 1'b0 || SecondsLeft !== SW'(0) || Tick !== 1'b0) begin
        n_errors++;
        $display("FAIL expired_hold cyc=%0d got done=%b sec=%0d tick=%b exp done=0 sec=0 tick=0",
                 i, TimerDone, SecondsLeft, Tick);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (SecondsLeft !== SW'(3) || DbgState !== 2'd0) begin
      n_errors++; $display("FAIL expired_rearm got sec=%0d st=%0d exp sec=3 st=0", SecondsLeft, DbgState);
    end
    step(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (SecondsLeft !== SW'(2) || Tick !== 1'b1) begin
      n_errors++; $display("FAIL expired_newgame got sec=%0d tick=%b exp sec=2 tick=1", SecondsLeft, Tick);
    end
  endtask

  task automatic test_reset_in_done();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (TimerDone !== 1'b1 || DbgState !== 2'd2) begin
      n_errors++; $display("FAIL rdone_pre got done=%b st=%0d exp done=1 st=2", TimerDone, DbgState);
    end
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (TimerDone !== 1'b0 || SecondsLeft !== SW'(3) || DbgState !== 2'd0 || Tick !== 1'b0) begin
      n_errors++;
      $display("FAIL rdone_reset got done=%b sec=%0d st=%0d tick=%b exp done=0 sec=3 st=0 tick=0",
               TimerDone, SecondsLeft, DbgState, Tick);
    end
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (DbgState !== 2'd1 || SecondsLeft !== SW'(3)) begin
      n_errors++; $display("FAIL rdone_rerun got st=%0d sec=%0d exp st=1 sec=3", DbgState, SecondsLeft);
    end
  endtask

  task automatic test_random();
    logic r, s, p;
    s = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 39) == 0) s = ~s;
      p = ($urandom_range(0, 3) == 0);
      step(r, s, p);
      n_checks++;
      if (TimerDone !== m_done || SecondsLeft !== m_sec || Tick !== m_tick) begin
        n_errors++;
        $display("FAIL random cyc=%0d got done=%b sec=%0d tick=%b exp done=%b sec=%0d tick=%b",
                 i, TimerDone, SecondsLeft, Tick, m_done, m_sec, m_tick);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b1; State = 1'b0; Pause = 1'b0;
    m_phase = 0; m_elapsed = 0; m_over = 0;
    m_done = 1'b0; m_tick = 1'b0; m_sec = SW'(GS);
    @(negedge Clock);
    test_reset();
    test_countdown("countdown");
    test_pause();
    test_abort();
    test_expired();
    test_reset_in_done();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Countdown timer that is the counterpart of the game-state FSM. It consumes that FSM's `State` output (1 = game in progress) and produces the `TimerDone` input that the FSM waits on.
- It divides `Clock` to a one-second tick, counts the game duration down, and raises `TimerDone` long enough for the FSM's wait-state handshake.
- It also exports the remaining seconds for the score/time display.

Parameters:
- CLOCK_HZ, 50000000: `Clock` cycles per game second. Minimum 2.
- GAME_SECONDS, 60: game duration in seconds. Range 1 .. 2^SEC_W-1; 0 is illegal.
- SEC_W, 7: width of `SecondsLeft`.
- DONE_HOLD, 2: number of cycles `TimerDone` stays high. Minimum 1.

Ports:
- Clock  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- State  in  1  game-in-progress flag from the game-state FSM.
- Pause  in  1  freezes the countdown while high (RUN only).
- TimerDone  out  1  registered; high for DONE_HOLD cycles at expiry.
- SecondsLeft  out  SEC_W  registered; remaining whole seconds.
- Tick  out  1  registered; one-cycle pulse on each decrement of `SecondsLeft`.

Behaviour:
- One clock, `Clock`. Reset is synchronous and active-high on `Reset`, and has priority over all other inputs in every state.
- Reset values:
  - FSM = IDLE, prescaler = 0, hold counter = 0.
  - SecondsLeft = GAME_SECONDS, TimerDone = 0, Tick = 0.
- Prescaler width is clog2(CLOCK_HZ). The hold counter is wide enough for DONE_HOLD.
- FSM states: IDLE, RUN, DONE, EXPIRED.
- IDLE:
  - SecondsLeft = GAME_SECONDS; prescaler cleared; TimerDone = 0.
  - `State` sampled 1 -> RUN on the next edge.
- RUN:
  - Each cycle with Pause=0, the prescaler increments. With Pause=1 the prescaler and SecondsLeft hold, and Tick = 0.
  - When prescaler == CLOCK_HZ-1 and Pause=0 on that edge:
    - prescaler -> 0, SecondsLeft -> SecondsLeft-1, Tick = 1 for that one cycle (coincident with the new SecondsLeft value).
  - If that decrement takes SecondsLeft from 1 to 0, the FSM moves to DONE on the same edge and TimerDone goes 1 on that edge.
  - `State` sampled 0 (game aborted) -> IDLE on the next edge, with reload. TimerDone is never asserted. If abort and the final tick coincide, abort wins.
  - First decrement occurs CLOCK_HZ unpaused cycles after RUN entry. Expiry occurs GAME_SECONDS*CLOCK_HZ unpaused cycles after RUN entry.
- DONE:
  - TimerDone = 1 and SecondsLeft = 0; Pause is ignored.
  - The hold counter counts DONE_HOLD cycles, then EXPIRED with TimerDone -> 0.
  - `State` sampled 0 -> IDLE immediately, TimerDone -> 0.
- EXPIRED:
  - TimerDone = 0, SecondsLeft = 0, no counting; Pause is ignored.
  - Waits for `State` = 0, then IDLE. There is no restart while `State` stays 1, which covers the FSM's wait state where `State` is still 1.
- Arithmetic:
  - SecondsLeft never wraps below 0; no decrement occurs outside RUN.
  - The prescaler never exceeds CLOCK_HZ-1.
- New game: `State` 0 -> 1 after any completion or abort always starts from GAME_SECONDS with the prescaler at 0.
- No combinational path from inputs to outputs.

Test Plan:
All scenarios use CLOCK_HZ=4, GAME_SECONDS=3, DONE_HOLD=2.
1. Reset held 3 cycles, then released with State=0 -> SecondsLeft=3, TimerDone=0, Tick=0, and they remain so for 20 cycles.
2. State=1 held; RUN entered at edge E0:
   - Tick pulses at E4, E8, E12; SecondsLeft goes 2, 1, 0 respectively.
   - TimerDone=1 at E12–E13, 0 from E14 onward.
3. As scenario 2, but Pause=1 for 5 cycles starting at E6:
   - Decrements at E4, E13, E17.
   - TimerDone high E17–E18.
   - No Tick during the pause.
4. State dropped to 0 while SecondsLeft=2 (at E6) -> IDLE next edge, SecondsLeft=3, TimerDone never asserted. State re-raised -> full 12-cycle countdown repeats.
5. After expiry, State held 1 for 10 more cycles -> TimerDone stays 0 after its 2-cycle hold, SecondsLeft=0, no Tick. Then State 0 for 1 cycle and back to 1 -> SecondsLeft=3 and a new countdown starts.
6. Reset asserted for 1 cycle during DONE (first TimerDone cycle) -> next cycle TimerDone=0, SecondsLeft=3, FSM IDLE. With State still 1, RUN is re-entered on the following edge.
